// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith ops plus a shift-add multiplier that
// takes WIDTH steps. Results and flags are held until the next done pulse.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       alu_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             carry_o,
  output logic             overflow_o
);

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpMul
  } op_e;

  typedef enum logic {StIdle, StMul} state_e;

  localparam logic [SHW:0] LastStep = (SHW+1)'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   zero_q, zero_d, neg_q, neg_d;
  logic                   carry_q, carry_d, ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [SHW:0]           cnt_q, cnt_d;

  op_e                    op;
  logic [WIDTH:0]         sum_ext;
  logic [WIDTH-1:0]       b_opnd;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c, alu_v;
  int unsigned            shamt;
  logic [2*WIDTH-1:0]     acc_step;

  assign op = op_e'(alu_op_i);

  // Single-cycle datapath; SUB reuses the adder with inverted B and carry-in.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    b_opnd  = (op == OpSub) ? ~b_i : b_i;
    sum_ext = {1'b0, a_i} + {1'b0, b_opnd} + (WIDTH+1)'(op == OpSub);
    shamt   = 32'(b_i[SHW-1:0]) % WIDTH;
    unique case (op)
      OpAdd, OpSub: begin
        alu_res = sum_ext[WIDTH-1:0];
        // Carry-out of a + ~b + 1 is the inverse of the unsigned borrow.
        alu_c   = (op == OpSub) ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
        alu_v   = (a_i[WIDTH-1] == b_opnd[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OpAnd:   alu_res = a_i & b_i;
      OpOr:    alu_res = a_i | b_i;
      OpXor:   alu_res = a_i ^ b_i;
      OpShl:   alu_res = a_i << shamt;
      OpShr:   alu_res = a_i >> shamt;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Control FSM next state plus result/flag capture.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (op == OpMul) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final step is folded into the result capture so done lands WIDTH edges later.
        if (cnt_q == LastStep) begin
          result_d = acc_step[WIDTH-1:0];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          neg_d    = acc_step[WIDTH-1];
          carry_d  = |acc_step[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign negative_o = neg_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors with literal expectations, plus a cycle-level
// reference model checked against the DUT on every falling edge.
module tb_alu_seq;

  localparam int W = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [2:0]   alu_op_i;
  logic [W-1:0] a_i, b_i;
  logic         ready_o, done_o, zero_o, negative_o, carry_o, overflow_o;
  logic [W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_seq #(.WIDTH(W), .SHW(3)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .alu_op_i   (alu_op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .negative_o (negative_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, n, c, v;
  } res_t;

  // What the ALU must produce, from plain arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, b);
    res_t r;
    logic [15:0] p;
    logic [8:0]  s;
    r = '0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[7:0];
        r.c = s[8];
        r.v = (a[7] == b[7]) && (r.res[7] != a[7]);
      end
      SUB: begin
        r.res = a - b;
        r.c = (a < b);
        r.v = (a[7] != b[7]) && (r.res[7] != a[7]);
      end
      AND_: r.res = a & b;
      OR_:  r.res = a | b;
      XOR_: r.res = a ^ b;
      SHL:  r.res = a << (b % 8);
      SHR:  r.res = a >> (b % 8);
      default: begin
        p = 16'(a) * 16'(b);
        r.res = p[7:0];
        r.c = (p[15:8] != 0);
      end
    endcase
    r.z = (r.res == 0);
    r.n = r.res[7];
    return r;
  endfunction

  res_t m_out, m_pend;
  logic m_done, m_busy;
  int   m_left;

  // Reference: non-MUL completes at the accept edge, MUL eight edges later.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_out <= '0; m_pend <= '0; m_done <= 1'b0; m_busy <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_out <= m_pend; m_done <= 1'b1;
        end
      end else if (start_i) begin
        if (alu_op_i == MUL) begin
          m_busy <= 1'b1; m_left <= W; m_pend <= model(alu_op_i, a_i, b_i);
        end else begin
          m_out <= model(alu_op_i, a_i, b_i); m_done <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      cmp("model done", 16'(done_o), 16'(m_done));
      cmp("model ready", 16'(ready_o), 16'(!m_busy));
      cmp("model out", 16'({result_o, zero_o, negative_o, carry_o, overflow_o}), 16'(m_out));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic d, input logic [7:0] r,
                         input logic z, n, c, v);
    cmp(nm, 16'({done_o, result_o, zero_o, negative_o, carry_o, overflow_o}),
        16'({d, r, z, n, c, v}));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, b);
    start_i = 1'b1; alu_op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0;
  endtask

  // Issue a MUL, optionally pulse an ADD start mid-operation, check latency.
  task automatic run_mul(input string nm, input logic [7:0] a, b, input int poke);
    int n;
    run_op(MUL, a, b);
    cmp({nm, " busy"}, 16'(ready_o), 16'd0);
    n = 0;
    while (!done_o && n < 20) begin
      if (n == poke) begin
        start_i = 1'b1; alu_op_i = ADD; a_i = 8'h11; b_i = 8'h22;
      end else begin
        start_i = 1'b0; a_i = 8'hA5; b_i = 8'h5A;
      end
      tick();
      n++;
    end
    start_i = 1'b0;
    cmp({nm, " latency"}, 16'(n), 16'(W));
  endtask

  typedef struct {logic [2:0] op; logic [7:0] a, b;} vec_t;
  vec_t vecs[8] = '{
    '{ADD, 8'h7F, 8'h01}, '{ADD, 8'h80, 8'h80}, '{SUB, 8'h05, 8'h05},
    '{AND_, 8'hCC, 8'h0F}, '{OR_, 8'hA0, 8'h05}, '{SHL, 8'h81, 8'h09},
    '{SHR, 8'h81, 8'h08}, '{SUB, 8'h7F, 8'hFF}
  };

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; alu_op_i = ADD; a_i = '0; b_i = '0;
    tick(); tick();
    chk_en = 1'b1;
    chk_out("reset out", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset ready", 16'(ready_o), 16'd1);
    rst_ni = 1'b1;
    tick();

    run_op(ADD, 8'hFF, 8'h01);
    chk_out("add ff+01", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    cmp("done pulse", 16'(done_o), 16'd0);
    run_op(SUB, 8'h80, 8'h01);
    chk_out("sub 80-01", 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(SUB, 8'h01, 8'h02);
    chk_out("sub 01-02", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    run_mul("mul 0d*0b", 8'h0D, 8'h0B, -1);
    chk_out("mul 0d*0b out", 1'b1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    run_mul("mul 10*10", 8'h10, 8'h10, -1);
    chk_out("mul 10*10 out", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    run_mul("mul poke", 8'h0D, 8'h0B, 3);
    chk_out("mul poke out", 1'b1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    cmp("poke no done", 16'(done_o), 16'd0);

    run_op(XOR_, 8'hF0, 8'hFF);
    chk_out("b2b xor", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(SHR, 8'h80, 8'h03);
    chk_out("b2b shr", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(SHL, 8'h5A, 8'h00);
    chk_out("shl by 0", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(SHL, 8'h81, 8'h09);
    chk_out("shl by 9", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(ADD, 8'h7F, 8'h01);
    chk_out("add ovf", 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();

    // Abort a multiply after four steps.
    run_op(MUL, 8'hFF, 8'hFF);
    repeat (4) tick();
    rst_ni = 1'b0;
    #1;
    chk_out("abort out", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("abort ready", 16'(ready_o), 16'd1);
    #1 rst_ni = 1'b1;
    repeat (10) begin
      tick();
      cmp("abort no done", 16'(done_o), 16'd0);
    end
    run_op(ADD, 8'h05, 8'h03);
    chk_out("add after abort", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b);
    run_mul("mul ff*ff", 8'hFF, 8'hFF, -1);
    chk_out("mul ff*ff out", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
